// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: drains 16-bit words from a show-ahead FIFO and sends each one
// as two 8N1-style UART frames, low byte first. All pacing lives here; the
// FIFO only ever sees a one-cycle pop strobe while this block is idle.
//
// Handshake with the FIFO (valid/ready style): fifo_empty=0 means fifo_rdata
// is a valid head word; fifo_ren is the ready/accept strobe. A word moves when
// both are true in the same cycle. fifo_rdata is captured on that edge, and
// fifo_ren is never raised outside IDLE or while rst is held, so the FIFO is
// never popped for a word that cannot be sent.
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] fifo_rdata,
    input  logic        fifo_empty,
    output logic        fifo_ren,
    output logic        tx,
    output logic        busy
);

    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    // stop_cnt only needs to reach 1 because at most two stop bits are sent.
    localparam logic STOP_LAST = (STOP_BITS == 2);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t         state;
    logic [15:0]    word;
    logic           byte_sel;
    logic [2:0]     bit_idx;
    logic [BW-1:0]  baud_cnt;
    logic           stop_cnt;
    logic [2:0]     next_idx;
    logic           baud_end;

    // Pop strobe: only in IDLE, only when the FIFO has a word, never during reset.
    assign fifo_ren = (state == IDLE) & ~fifo_empty & ~rst;

    // Index of the data bit that follows the current one within a byte.
    assign next_idx = bit_idx + 3'd1;

    // Last cycle of the current serial bit.
    assign baud_end = (baud_cnt == BAUD_LAST);

    // Frame sequencer; tx and busy are registered alongside the state so they
    // change on the same edge as the state they describe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            word     <= '0;
            byte_sel <= 1'b0;
            bit_idx  <= '0;
            baud_cnt <= '0;
            stop_cnt <= 1'b0;
            tx       <= 1'b1;
            busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (fifo_ren) begin
                        word     <= fifo_rdata;
                        byte_sel <= 1'b0;
                        bit_idx  <= '0;
                        baud_cnt <= '0;
                        stop_cnt <= 1'b0;
                        state    <= START;
                        tx       <= 1'b0;
                        busy     <= 1'b1;
                    end else begin
                        tx   <= 1'b1;
                        busy <= 1'b0;
                    end
                end

                START: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        state    <= DATA;
                        tx       <= word[{byte_sel, 3'd0}];
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                DATA: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            stop_cnt <= 1'b0;
                            state    <= STOP;
                            tx       <= 1'b1;
                        end else begin
                            bit_idx <= next_idx;
                            tx      <= word[{byte_sel, next_idx}];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                STOP: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        if (stop_cnt == STOP_LAST) begin
                            stop_cnt <= 1'b0;
                            if (!byte_sel) begin
                                // Low byte done: send the high byte of the same word.
                                byte_sel <= 1'b1;
                                bit_idx  <= '0;
                                state    <= START;
                                tx       <= 1'b0;
                            end else begin
                                byte_sel <= 1'b0;
                                bit_idx  <= '0;
                                state    <= IDLE;
                                tx       <= 1'b1;
                                busy     <= 1'b0;
                            end
                        end else begin
                            stop_cnt <= stop_cnt + 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: two instances (one and two stop bits) fed by queue
// models of a show-ahead FIFO; a byte scoreboard checks the serial output.
module tb_fifo_uart_tx;

  localparam int CPB = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT wiring ----------------
  logic [15:0] f1_rdata = '0;
  logic [15:0] f2_rdata = '0;
  logic        f1_empty = 1'b1;
  logic        f2_empty = 1'b1;
  logic        ren1, tx1, busy1;
  logic        ren2, tx2, busy2;

  fifo_uart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_rdata (f1_rdata),
    .fifo_empty (f1_empty),
    .fifo_ren   (ren1),
    .tx         (tx1),
    .busy       (busy1)
  );

  fifo_uart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(2)) dut2 (
    .clk        (clk),
    .rst        (rst),
    .fifo_rdata (f2_rdata),
    .fifo_empty (f2_empty),
    .fifo_ren   (ren2),
    .tx         (tx2),
    .busy       (busy2)
  );

  // ---------------- FIFO models and scoreboard ----------------
  logic [15:0] f1_q[$];
  logic [15:0] f2_q[$];
  logic [7:0]  exp_q[$];

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int ren1_cnt = 0;
  int ren2_cnt = 0;
  int idle_low = 0;

  // Pop on the edge where ren is high; flags refresh just after the edge.
  always @(posedge clk) begin
    cyc++;
    if (ren1 && f1_q.size() > 0) f1_q.delete(0);
    if (ren2 && f2_q.size() > 0) f2_q.delete(0);
    #1;
    f1_empty = (f1_q.size() == 0);
    f1_rdata = (f1_q.size() > 0) ? f1_q[0] : 16'h0000;
    f2_empty = (f2_q.size() == 0);
    f2_rdata = (f2_q.size() > 0) ? f2_q[0] : 16'h0000;
  end

  // Pop pulse counters and idle-line watch, sampled mid-cycle.
  always @(negedge clk) begin
    if (ren1 === 1'b1) ren1_cnt++;
    if (ren2 === 1'b1) ren2_cnt++;
    if ((busy1 === 1'b0 && tx1 !== 1'b1) || (busy2 === 1'b0 && tx2 !== 1'b1)) idle_low++;
  end

  // ---------------- driver / checker tasks ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic push(input bit sel, input logic [15:0] w);
    if (sel) f2_q.push_back(w);
    else     f1_q.push_back(w);
    exp_q.push_back(w[7:0]);
    exp_q.push_back(w[15:8]);
  endtask

  // Waits for a pop on the selected DUT, then decodes both frames cycle by
  // cycle, checking start/stop levels, bit stability, busy and no extra pops.
  // Returns at the negedge of the last stop cycle of the high byte.
  task automatic rx_word(input bit sel, input bit do_push, input logic [15:0] push_w,
                         output int t_pop);
    bit         ok;
    logic [7:0] d;
    logic [7:0] e;
    logic [4:0] bad;
    int         stop_len;
    string      tag;
    logic       s_tx;
    ok = 1'b0;
    t_pop = -1;
    bad = '0;
    d = '0;
    stop_len = sel ? 2 * CPB : CPB;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      if ((sel ? ren2 : ren1) === 1'b1) ok = 1'b1;
    end
    check("pop_seen", {31'd0, ok}, 32'd1);
    if (!ok) return;
    t_pop = cyc;
    for (int b = 0; b < 2; b++) begin
      for (int c = 0; c < CPB; c++) begin
        @(negedge clk);
        if ((sel ? tx2 : tx1) !== 1'b0) bad[0] = 1'b1;
        if ((sel ? busy2 : busy1) !== 1'b1) bad[3] = 1'b1;
        if ((sel ? ren2 : ren1) !== 1'b0) bad[4] = 1'b1;
      end
      for (int i = 0; i < 8; i++) begin
        for (int c = 0; c < CPB; c++) begin
          @(negedge clk);
          s_tx = sel ? tx2 : tx1;
          if (c == 0) d[i] = s_tx;
          else if (s_tx !== d[i]) bad[1] = 1'b1;
          if ((sel ? busy2 : busy1) !== 1'b1) bad[3] = 1'b1;
          if ((sel ? ren2 : ren1) !== 1'b0) bad[4] = 1'b1;
          if (do_push && b == 0 && i == 0 && c == 0) push(sel, push_w);
        end
      end
      for (int c = 0; c < stop_len; c++) begin
        @(negedge clk);
        if ((sel ? tx2 : tx1) !== 1'b1) bad[2] = 1'b1;
        if ((sel ? busy2 : busy1) !== 1'b1) bad[3] = 1'b1;
        if ((sel ? ren2 : ren1) !== 1'b0) bad[4] = 1'b1;
      end
      e = 8'hxx;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      tag = (b == 0) ? "byte_lo" : "byte_hi";
      check(tag, {24'd0, d}, {24'd0, e});
    end
    check("frame_shape", {27'd0, bad}, 32'd0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int t_rel, t0, t1, t2, r0, viol;
    bit ok;

    // Reset with a word already queued: no pop while held, pop right after release.
    #2 rst = 1'b1;
    push(0, 16'hA55A);
    repeat (3) @(negedge clk);
    check("rst_tx", {31'd0, tx1}, 32'd1);
    check("rst_busy", {31'd0, busy1}, 32'd0);
    check("rst_ren_gated", {31'd0, ren1}, 32'd0);
    r0 = ren1_cnt;
    @(posedge clk);
    #2 rst = 1'b0;
    t_rel = cyc;
    rx_word(0, 1'b0, 16'h0000, t0);
    check("pop_after_release", t0, t_rel);
    @(negedge clk);
    check("single_idle_busy", {31'd0, busy1}, 32'd0);
    check("single_idle_tx", {31'd0, tx1}, 32'd1);
    check("single_pop_count", ren1_cnt - r0, 32'd1);

    // Empty FIFO held for 200 cycles.
    viol = 0;
    repeat (200) begin
      @(negedge clk);
      if (ren1 !== 1'b0 || tx1 !== 1'b1 || busy1 !== 1'b0) viol++;
    end
    check("empty_hold", viol, 32'd0);

    // Back-to-back words.
    r0 = ren1_cnt;
    push(0, 16'h0001);
    push(0, 16'h8000);
    push(0, 16'hFFFF);
    rx_word(0, 1'b0, 16'h0000, t0);
    rx_word(0, 1'b0, 16'h0000, t1);
    rx_word(0, 1'b0, 16'h0000, t2);
    check("b2b_gap1", t1 - t0, 32'd81);
    check("b2b_gap2", t2 - t1, 32'd81);
    check("b2b_pops", ren1_cnt - r0, 32'd3);

    // Producer writes while busy; then a word that appears exactly on IDLE arrival.
    @(negedge clk);
    push(0, 16'hC3A5);
    rx_word(0, 1'b1, 16'h5A3C, t0);
    rx_word(0, 1'b0, 16'h0000, t1);
    check("busy_push_gap", t1 - t0, 32'd81);
    push(0, 16'h7E81);
    rx_word(0, 1'b0, 16'h0000, t2);
    check("same_cycle_pop_gap", t2 - t1, 32'd81);

    // Reset during data bit 3 of the low byte.
    @(negedge clk);
    push(0, 16'hBEEF);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (ren1 === 1'b1) ok = 1'b1;
    end
    check("mid_pop_seen", {31'd0, ok}, 32'd1);
    repeat (18) @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_mid_tx", {31'd0, tx1}, 32'd1);
    check("rst_mid_busy", {31'd0, busy1}, 32'd0);
    exp_q.delete();
    push(0, 16'h1234);
    repeat (2) @(negedge clk);
    check("rst_mid_ren_gated", {31'd0, ren1}, 32'd0);
    @(posedge clk);
    #2 rst = 1'b0;
    t_rel = cyc;
    rx_word(0, 1'b0, 16'h0000, t0);
    check("pop_after_mid_rst", t0, t_rel);

    // Two stop bits on the second instance.
    @(negedge clk);
    push(1, 16'h00FF);
    push(1, 16'h3CA5);
    rx_word(1, 1'b0, 16'h0000, t0);
    rx_word(1, 1'b0, 16'h0000, t1);
    check("sb2_gap", t1 - t0, 32'd89);
    @(negedge clk);
    check("sb2_idle_busy", {31'd0, busy2}, 32'd0);

    // Totals.
    check("idle_tx_low", idle_low, 32'd0);
    check("dut1_pop_total", ren1_cnt, 32'd9);
    check("dut2_pop_total", ren2_cnt, 32'd2);
    check("scoreboard_drained", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
